dm_arbiter: RTL and testbench

- Arbitrates the single-port 128x32 data memory between the pipeline MEM stage (CPU port) and a DMA/loader port.
- The CPU has default priority. A starvation counter forces a DMA slot after STARVE_MAX consecutive denied cycles, and the CPU is stalled during that slot.
- Sits between the MEM-stage pipeline register logic and the data memory array. Read data is returned registered, one cycle after the access.

---
 rtl/dm_pkg.sv | 14 +
 rtl/dm_sram.sv | 32 +++
 rtl/dm_arbiter.sv | 97 +++++++++
 tb/tb_dm_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared sizes and the read-return owner encoding for the data-memory arbiter.
package dm_pkg;
  localparam int DM_ADDR_W     = 7;
  localparam int DM_DATA_W     = 32;
  localparam int DM_DEPTH      = 128;
  localparam int DM_STARVE_MAX = 4;
  localparam int DM_CNT_W      = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_DMA
  } owner_t;
endpackage

// File: rtl/dm_sram.sv
// Single-port data memory: write commits at posedge, reads land in an output register.
module dm_sram
  import dm_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // The array is never reset; the read register only changes on a read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end else begin
        rdata_q <= mem_q[addr];
      end
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/dm_arbiter.sv
// CPU/DMA arbiter for the data memory: CPU-first priority with a starvation-forced
// DMA slot, and steering of the registered read data back to whichever port asked.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W     = DM_ADDR_W,
  parameter int DATA_W     = DM_DATA_W,
  parameter int STARVE_MAX = DM_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid
);
  localparam logic [DM_CNT_W-1:0] STARVE_LIM = DM_CNT_W'(STARVE_MAX);

  logic [DM_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  owner_t              owner_q, owner_d;
  logic [DATA_W-1:0]   cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0]   dma_hold_q, dma_hold_d;

  logic              force_dma, dma_win, cpu_win;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  // Reset masks both winners so no grant, stall or memory access leaks out while rst is high.
  always_comb begin
    force_dma = dma_req & (starve_cnt_q == STARVE_LIM);
    dma_win   = ~rst & dma_req & (~cpu_req | force_dma);
    cpu_win   = ~rst & cpu_req & ~dma_win;
    mem_en    = dma_win | cpu_win;
    mem_we    = dma_win ? dma_we    : cpu_we;
    mem_addr  = dma_win ? dma_addr  : cpu_addr;
    mem_wdata = dma_win ? dma_wdata : cpu_wdata;
  end

  always_comb begin
    starve_cnt_d = '0;
    owner_d      = OWN_NONE;
    cpu_hold_d   = cpu_rdata;
    dma_hold_d   = dma_rdata;
    if (!dma_win && dma_req && cpu_req) begin
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 1'b1;
    end
    if (dma_win && !dma_we) begin
      owner_d = OWN_DMA;
    end else if (cpu_win && !cpu_we) begin
      owner_d = OWN_CPU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_q <= '0;
      owner_q      <= OWN_NONE;
      cpu_hold_q   <= '0;
      dma_hold_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      cpu_hold_q   <= cpu_hold_d;
      dma_hold_q   <= dma_hold_d;
    end
  end

  // The SRAM output register is shown only to the port that owns the return; the
  // hold registers give MDR-style persistence without adding a cycle of latency.
  assign cpu_rdata  = (owner_q == OWN_CPU) ? mem_rdata : cpu_hold_q;
  assign dma_rdata  = (owner_q == OWN_DMA) ? mem_rdata : dma_hold_q;
  assign dma_rvalid = (owner_q == OWN_DMA);
  assign dma_gnt    = dma_win;
  assign cpu_stall  = cpu_req & dma_win;

  dm_sram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_sram (
    .clk  (clk),
    .en   (mem_en),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized CPU/DMA traffic, all
// compared against a transaction-level model of the memory and arbitration rules.
module tb_dm_arbiter;
  import dm_pkg::*;

  localparam int SM = DM_STARVE_MAX;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req, cpu_we, cpu_stall;
  logic [6:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [6:0]  dma_addr;
  logic [31:0] dma_wdata, dma_rdata;

  always #5 clk = ~clk;

  dm_arbiter #(
    .ADDR_W(DM_ADDR_W),
    .DATA_W(DM_DATA_W),
    .STARVE_MAX(SM)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a plain array for the memory, a count of consecutive lost
  // DMA cycles, and the values each read port should be showing.
  logic [31:0] refMem [DM_DEPTH];
  int          denied;
  logic [31:0] expCpuRdata, expDmaRdata;
  logic        expRvalid;
  logic        mGnt, mStall;
  logic        obsGnt, obsStall;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    denied      = 0;
    expCpuRdata = '0;
    expDmaRdata = '0;
    expRvalid   = 1'b0;
  endtask

  task automatic setInputs(input logic cr, input logic cw, input logic [6:0] ca, input logic [31:0] cd,
                           input logic dr, input logic dw, input logic [6:0] da, input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  // One full cycle: entered just after a negedge, returns just after the next negedge.
  task automatic applyStimulus(input logic cr, input logic cw, input logic [6:0] ca, input logic [31:0] cd,
                               input logic dr, input logic dw, input logic [6:0] da, input logic [31:0] dd);
    setInputs(cr, cw, ca, cd, dr, dw, da, dd);
    mGnt   = dr && (!cr || denied >= SM);
    mStall = cr && mGnt;
    #1;
    obsGnt   = dma_gnt;
    obsStall = cpu_stall;
    checkOutput("dma_gnt",    32'(dma_gnt),    32'(mGnt));
    checkOutput("cpu_stall",  32'(cpu_stall),  32'(mStall));
    checkOutput("dma_rvalid", 32'(dma_rvalid), 32'(expRvalid));
    checkOutput("cpu_rdata",  cpu_rdata,       expCpuRdata);
    checkOutput("dma_rdata",  dma_rdata,       expDmaRdata);
    expRvalid = 1'b0;
    if (mGnt) begin
      if (dw) refMem[da] = dd;
      else begin
        expDmaRdata = refMem[da];
        expRvalid   = 1'b1;
      end
    end else if (cr) begin
      if (cw) refMem[ca] = cd;
      else expCpuRdata = refMem[ca];
    end
    if (mGnt) denied = 0;
    else if (dr && cr) denied = denied + 1;
    else denied = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle with the given inputs still applied.
  task automatic pulseReset(input string tag);
    #3;
    rst = 1'b1;
    #1;
    checkOutput({tag, "_gnt"},    32'(dma_gnt),    32'd0);
    checkOutput({tag, "_stall"},  32'(cpu_stall),  32'd0);
    checkOutput({tag, "_rvalid"}, 32'(dma_rvalid), 32'd0);
    checkOutput({tag, "_cpu_rd"}, cpu_rdata,       32'd0);
    checkOutput({tag, "_dma_rd"}, dma_rdata,       32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        cReq, cWe, dReq, dWe, lastStall, lastGnt;
    logic [6:0]  cAddr, dAddr;
    logic [31:0] cData, dData;
    int          done, completed;

    modelReset();
    setInputs(0, 0, '0, '0, 0, 0, '0, '0);
    repeat (2) @(negedge clk);
    checkOutput("reset_gnt",    32'(dma_gnt),    32'd0);
    checkOutput("reset_rvalid", 32'(dma_rvalid), 32'd0);
    checkOutput("reset_cpu_rd", cpu_rdata,       32'd0);
    checkOutput("reset_dma_rd", dma_rdata,       32'd0);
    rst = 1'b0;

    for (int a = 0; a < DM_DEPTH; a++) begin
      applyStimulus(1, 1, 7'(a), $urandom, 0, 0, '0, '0);
    end

    // CPU-only write then read
    applyStimulus(1, 1, 7'd5, 32'hDEADBEEF, 0, 0, '0, '0);
    checkOutput("cpu_only_gnt", 32'(obsGnt), 32'd0);
    applyStimulus(1, 0, 7'd5, '0, 0, 0, '0, '0);
    checkOutput("cpu_only_stall", 32'(obsStall), 32'd0);
    checkOutput("cpu_only_rdata", cpu_rdata, 32'hDEADBEEF);

    // DMA-only write then read
    applyStimulus(0, 0, '0, '0, 1, 1, 7'd127, 32'h12345678);
    checkOutput("dma_only_wr_gnt", 32'(obsGnt), 32'd1);
    applyStimulus(0, 0, '0, '0, 1, 0, 7'd127, '0);
    checkOutput("dma_only_rd_gnt", 32'(obsGnt), 32'd1);
    checkOutput("dma_only_rvalid", 32'(dma_rvalid), 32'd1);
    checkOutput("dma_only_rdata", dma_rdata, 32'h12345678);
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
    checkOutput("dma_only_rvalid_off", 32'(dma_rvalid), 32'd0);

    // Cross-port write-then-read ordering
    applyStimulus(0, 0, '0, '0, 1, 1, 7'd10, 32'hA5A5A5A5);
    applyStimulus(1, 0, 7'd10, '0, 0, 0, '0, '0);
    checkOutput("cross_rdata", cpu_rdata, 32'hA5A5A5A5);

    // Load data holds across later CPU writes
    applyStimulus(1, 1, 7'd20, 32'h1, 0, 0, '0, '0);
    applyStimulus(1, 0, 7'd20, '0, 0, 0, '0, '0);
    checkOutput("hold_first", cpu_rdata, 32'h1);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1, 1, 7'(21 + j), 32'(100 + j), 0, 0, '0, '0);
      checkOutput($sformatf("hold_rdata_%0d", j), cpu_rdata, 32'h1);
      checkOutput($sformatf("hold_rvalid_%0d", j), 32'(dma_rvalid), 32'd0);
    end

    // Continuous contention: forced DMA slots at cycles SM and 2*SM+1
    done = 0;
    completed = 0;
    for (int k = 0; k < 2 * (SM + 1); k++) begin
      applyStimulus(1, done[0], 7'(40 + done), 32'(done), 1, 0, 7'd3, '0);
      checkOutput($sformatf("contend_gnt_c%0d", k), 32'(obsGnt), 32'((k == SM) || (k == 2 * SM + 1)));
      checkOutput($sformatf("contend_stall_c%0d", k), 32'(obsStall), 32'((k == SM) || (k == 2 * SM + 1)));
      if (!obsStall) begin
        done++;
        completed++;
      end
    end
    checkOutput("contend_cpu_done", 32'(completed), 32'(2 * SM));
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);

    // Reset while a DMA read return is being presented
    applyStimulus(1, 0, 7'd5, '0, 0, 0, '0, '0);
    applyStimulus(0, 0, '0, '0, 1, 0, 7'd127, '0);
    checkOutput("rst1_pre_rvalid", 32'(dma_rvalid), 32'd1);
    checkOutput("rst1_pre_cpu_rd", cpu_rdata, 32'hDEADBEEF);
    setInputs(0, 0, '0, '0, 1, 0, 7'd127, '0);
    pulseReset("rst1");

    // Reset with three DMA cycles already denied; history must be forgotten
    applyStimulus(1, 0, 7'd5, '0, 0, 0, '0, '0);
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1, 1, 7'(60 + j), 32'(j), 1, 0, 7'd127, '0);
      checkOutput($sformatf("rst2_pre_gnt_%0d", j), 32'(obsGnt), 32'd0);
    end
    setInputs(1, 1, 7'd63, '0, 1, 0, 7'd127, '0);
    pulseReset("rst2");
    for (int k = 0; k <= SM; k++) begin
      applyStimulus(1, 1, 7'(64 + k), 32'(k), 1, 0, 7'd127, '0);
      checkOutput($sformatf("rst2_post_gnt_c%0d", k), 32'(obsGnt), 32'(k == SM));
    end
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);

    // Randomized traffic honouring the stall-hold and DMA-hold handshakes
    cReq = 0; cWe = 0; cAddr = '0; cData = '0;
    dReq = 0; dWe = 0; dAddr = '0; dData = '0;
    lastStall = 0; lastGnt = 0;
    for (int i = 0; i < 600; i++) begin
      if (!lastStall) begin
        cReq  = ($urandom_range(0, 9) < 7);
        cWe   = 1'($urandom);
        cAddr = 7'($urandom);
        cData = $urandom;
      end
      if (!(dReq && !lastGnt && $urandom_range(0, 9) != 0)) begin
        dReq  = ($urandom_range(0, 9) < 4);
        dWe   = 1'($urandom);
        dAddr = 7'($urandom);
        dData = $urandom;
      end
      applyStimulus(cReq, cWe, cAddr, cData, dReq, dWe, dAddr, dData);
      lastStall = mStall;
      lastGnt   = mGnt;
    end
    applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
